// File: rtl/channel_frame_averager.sv
// channel_frame_averager: 4-channel box-car averager with frame-synchronous output commit.
// Optional VU-style peak hold with per-frame decay is enabled by defining CHANNEL_PEAK_HOLD_EN.
module channel_frame_averager #(
   parameter int AVG_LOG2   = 4,
   parameter int DECAY_STEP = 16
) (
   input  logic        clk_in,
   input  logic        reset_n,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic [1:0]  s_chan,
   input  logic [11:0] s_data,
   input  logic        vsync_in,
   output logic [11:0] channel_1,
   output logic [11:0] channel_2,
   output logic [11:0] channel_3,
   output logic [11:0] channel_4,
   output logic        update_pulse,
   output logic [3:0]  fresh
);
   localparam int AW = 12 + AVG_LOG2;
   localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam logic [CW-1:0] LAST = CW'((1 << AVG_LOG2) - 1);
   typedef enum logic {IDLE, COMMIT} state_t;
   state_t        r_state, w_next;
   logic          r_vs_d, r_update, w_rise, w_accept, w_last;
   logic [AW-1:0] r_acc [4];
   logic [CW-1:0] r_cnt [4];
   logic [11:0]   r_shadow [4];
   logic [11:0]   r_chan [4];
   logic [11:0]   w_commit [4];
   logic [3:0]    r_new, r_fresh;
   logic [AW-1:0] w_sum;
   logic [11:0]   w_avg;
`ifdef CHANNEL_PEAK_HOLD_EN
   localparam logic [11:0] DECAY = 12'(DECAY_STEP);
   logic [11:0]   w_dec [4];
`endif
   assign w_rise    = vsync_in & ~r_vs_d;
   assign w_accept  = s_valid & s_ready;
   assign w_sum     = r_acc[s_chan] + AW'(s_data);
   assign w_avg     = 12'(w_sum >> AVG_LOG2);
   assign w_last    = r_cnt[s_chan] == LAST;
   assign channel_1 = r_chan[0];
   assign channel_2 = r_chan[1];
   assign channel_3 = r_chan[2];
   assign channel_4 = r_chan[3];
   assign update_pulse = r_update;
   assign fresh     = r_fresh;
   // FSM state register
   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_next;
   end
   // Next state: a vsync rise buys exactly one COMMIT cycle with the input stalled
   always_comb begin
      w_next  = (r_state == IDLE && w_rise) ? COMMIT : IDLE;
      s_ready = (r_state == IDLE);
   end
   // Value loaded into each output at commit: plain shadow, or peak hold with linear decay
   always_comb begin
      for (int i = 0; i < 4; i++) begin
`ifdef CHANNEL_PEAK_HOLD_EN
         w_dec[i]    = (r_chan[i] > DECAY) ? r_chan[i] - DECAY : 12'd0;
         w_commit[i] = (r_shadow[i] >= w_dec[i]) ? r_shadow[i] : w_dec[i];
`else
         w_commit[i] = r_shadow[i];
`endif
      end
   end
   // Accumulate accepted samples per channel; at commit copy shadows out and report freshness
   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         r_vs_d   <= 1'b0;
         r_update <= 1'b0;
         r_new    <= '0;
         r_fresh  <= '0;
         for (int i = 0; i < 4; i++) begin
            r_acc[i]    <= '0;
            r_cnt[i]    <= '0;
            r_shadow[i] <= '0;
            r_chan[i]   <= '0;
         end
      end else begin
         r_vs_d   <= vsync_in;
         r_update <= (r_state == COMMIT);
         for (int i = 0; i < 4; i++) begin
            if (w_accept && s_chan == 2'(i)) begin
               r_acc[i]    <= w_last ? '0 : w_sum;
               r_cnt[i]    <= w_last ? '0 : r_cnt[i] + CW'(1);
               r_shadow[i] <= w_last ? w_avg : r_shadow[i];
               r_new[i]    <= r_new[i] | w_last;
            end
            if (r_state == COMMIT) begin
               r_chan[i]  <= w_commit[i];
               r_fresh[i] <= r_new[i];
               r_new[i]   <= 1'b0;
            end
         end
      end
   end
endmodule
